// File: rtl/mul16_share_arb_if.sv
// Requester/result bus of mul16_share_arb.
// master: the requester/consumer side. slave: the shared multiplier arbiter.
interface mul16_share_arb_if #(
  parameter int NREQ = 4,
  parameter int AW   = 12,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               res_valid;
  logic [IDW-1:0]     res_id;
  logic [AW-1:0]      res_data;
  logic               res_ready;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/mul16_share_arb.sv
// mul16_share_arb: one combinational 16x16 vedic multiplier shared round-robin
// between NREQ requesters scaling a signed AW-bit J by a Q1.15 coefficient.
// Sequence IDLE (grant) -> CALC (multiply) -> DONE (hold result until taken).
// Optional macro MUL_ROUND_EN: round-half-up before the FRAC shift instead of floor.

// Unsigned 16x16 multiplier, vertical-and-crosswise split into 8x8 partials.
module mul16_vedic (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] o_o
);
  logic [15:0] ll, lh, hl, hh;

  assign ll = 16'(a_i[7:0])  * 16'(b_i[7:0]);
  assign lh = 16'(a_i[7:0])  * 16'(b_i[15:8]);
  assign hl = 16'(a_i[15:8]) * 16'(b_i[7:0]);
  assign hh = 16'(a_i[15:8]) * 16'(b_i[15:8]);
  assign o_o = {hh, 16'h0000} + {8'h00, lh, 8'h00} + {8'h00, hl, 8'h00} + {16'h0000, ll};
endmodule

module mul16_share_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 12,
  parameter int IDW  = 2,
  parameter int FRAC = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  mul16_share_arb_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic signed [32:0] QMAX = (33'sd1 <<< (AW-1)) - 33'sd1;
  localparam logic signed [32:0] QMIN = -(33'sd1 <<< (AW-1));

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [15:0]      ma_q, ma_d, mb_q, mb_d;
  logic signed [32:0] p_q, p_d;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_any;
  logic [AW-1:0]    sel_a, abs_a;
  logic [15:0]      sel_b, abs_b;
  logic [31:0]      prod;
  logic signed [32:0] prod_s, q;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any     = 1'b1;
        gnt_id      = IDW'(idx);
        gnt[idx]    = 1'b1;
      end
    end
  end

  // Operand select and magnitude of the granted requester.
  always_comb begin
    sel_a = bus.req_a[gnt_id*AW +: AW];
    sel_b = bus.req_b[gnt_id*16 +: 16];
    abs_a = sel_a[AW-1] ? (~sel_a + 1'b1) : sel_a;
    abs_b = sel_b[15]   ? (~sel_b + 1'b1) : sel_b;
  end

  mul16_vedic u_mul (
    .a_i (ma_q),
    .b_i (mb_q),
    .o_o (prod)
  );

  assign prod_s = $signed({1'b0, prod});

  // State and operand registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ-1);
      id_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      p_q     <= p_d;
    end
  end

  // Next-state: grant in IDLE, signed product in CALC, hold in DONE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          sa_d    = sel_a[AW-1];
          sb_d    = sel_b[15];
          ma_d    = 16'(abs_a);
          mb_d    = abs_b;
          id_d    = gnt_id;
          ptr_d   = gnt_id;
          state_d = CALC;
        end
      end
      CALC: begin
        // Magnitude product is unsigned, so a zero result stays 0 after negation.
        p_d = (sa_q ^ sb_q) ? -prod_s : prod_s;
`ifdef MUL_ROUND_EN
        p_d = p_d + (33'sd1 <<< (FRAC-1));
`endif
        state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Floor shift then clamp to the AW-bit signed range.
  always_comb begin
    q = p_q >>> FRAC;
    if (q > QMAX)      bus.res_data = {1'b0, {(AW-1){1'b1}}};
    else if (q < QMIN) bus.res_data = {1'b1, {(AW-1){1'b0}}};
    else               bus.res_data = q[AW-1:0];
  end

  assign bus.req_ready = (rst_n && state_q == IDLE) ? gnt : '0;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_id    = id_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mul16_share_arb.sv
// Directed bench for mul16_share_arb: latency, sign/zero/saturation, round-robin
// order, backpressure and reset during CALC.
module tb_mul16_share_arb;
  localparam int NREQ = 4;
  localparam int AW   = 12;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mul16_share_arb_if #(.NREQ(NREQ), .AW(AW), .IDW(IDW)) bus ();

  mul16_share_arb #(.NREQ(NREQ), .AW(AW), .IDW(IDW), .FRAC(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [AW-1:0] a, input logic [15:0] b);
    bus.req_a[id*AW +: AW] = a;
    bus.req_b[id*16 +: 16] = b;
  endtask

  // One isolated operation on requester id, checking latency and result.
  task automatic run_one(input string tag, input int id, input logic [AW-1:0] a,
                         input logic [15:0] b, input logic [AW-1:0] exp);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    set_req(id, a, b);
    bus.req_valid = oh;
    #1;
    chk({tag, "_grant"}, 32'(bus.req_ready), 32'(oh));
    tick();
    bus.req_valid = '0;
    #1;
    chk({tag, "_calc_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_calc_novld"}, 32'(bus.res_valid), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(bus.res_valid), 32'd1);
    chk({tag, "_id"}, 32'(bus.res_id), 32'(id));
    chk({tag, "_data"}, 32'(bus.res_data), 32'(exp));
    tick();
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [NREQ-1:0] oh;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_id",    32'(bus.res_id),    32'd0);
    chk("rst_data",  32'(bus.res_data),  32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    rst_n = 1'b1;
    tick();

    // Single operation, floor vs round
`ifdef MUL_ROUND_EN
    run_one("basic", 0, 12'hC74, 16'h43CF, 12'hE1F);
    run_one("sat_pos2", 1, 12'h7FF, 16'h7FFF, 12'h7FF);
`else
    run_one("basic", 0, 12'hC74, 16'h43CF, 12'hE1E);
    run_one("sat_pos2", 1, 12'h7FF, 16'h7FFF, 12'h7FE);
`endif
    run_one("sat_pos", 2, 12'h800, 16'h8000, 12'h7FF);
    run_one("zero_a", 3, 12'h000, 16'h8000, 12'h000);
`ifdef MUL_ROUND_EN
    run_one("neg_tiny", 0, 12'h001, 16'hFFFF, 12'h000);
`else
    run_one("neg_tiny", 0, 12'h001, 16'hFFFF, 12'hFFF);
`endif
    run_one("neg_big", 2, 12'h7FF, 16'h8000, 12'h801);

    // Round-robin: fresh reset so requester 0 goes first; lane i gives 8*(i+1)
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 12'(16*(i+1)), 16'h4000);
    bus.req_valid = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      oh = '0;
      oh[order[g]] = 1'b1;
      chk("rr_grant", 32'(bus.req_ready), 32'(oh));
      tick();
      chk("rr_calc_noready", 32'(bus.req_ready), 32'd0);
      tick();
      chk("rr_id", 32'(bus.res_id), 32'(order[g]));
      chk("rr_data", 32'(bus.res_data), 32'(8*(order[g]+1)));
      chk("rr_done_noready", 32'(bus.req_ready), 32'd0);
      tick();
    end

    // Backpressure: pointer now at 0, so requester 1 is next
    bus.res_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(bus.req_ready), 32'b0010);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_data", 32'(bus.res_data), 32'd16);
      chk("bp_noready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    chk("bp_release_valid", 32'(bus.res_valid), 32'd1);
    tick();
    chk("bp_idle_valid", 32'(bus.res_valid), 32'd0);
    chk("bp_next_grant", 32'(bus.req_ready), 32'b0100);
    bus.req_valid = '0;
    #1;
    tick();

    // Reset during CALC discards the result and restores priority to 0
    set_req(3, 12'h123, 16'h4000);
    bus.req_valid = 4'b1000;
    #1;
    chk("rstcalc_grant", 32'(bus.req_ready), 32'b1000);
    tick();
    chk("rstcalc_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    bus.req_valid = '0;
    tick();
    chk("rstcalc_valid", 32'(bus.res_valid), 32'd0);
    chk("rstcalc_idle", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    bus.req_valid = '1;
    #1;
    chk("rstcalc_first", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
